// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline defines: NOP field encodings, inter-stage payload widths,
// the matching bubble payloads, and the boundary-register state type.
package pipe_stage_reg_pkg;

    localparam int unsigned ALUOP_W   = 8;
    localparam int unsigned ALUSEL_W  = 3;
    localparam int unsigned REG_W     = 32;
    localparam int unsigned REGADDR_W = 5;

    localparam logic [ALUOP_W-1:0]   EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [ALUSEL_W-1:0]  EXE_RES_NOP  = 3'b000;
    localparam logic [REG_W-1:0]     ZeroWord     = 32'h0000_0000;
    localparam logic [REGADDR_W-1:0] NOPRegAddr   = 5'b00000;
    localparam logic                 WriteDisable = 1'b0;

    // ID/EX: aluop, alusel, reg1, reg2, waddr, we
    localparam int unsigned ID_EX_W  = ALUOP_W + ALUSEL_W + 2 * REG_W + REGADDR_W + 1;
    // EX/MEM and MEM/WB: waddr, we, wdata
    localparam int unsigned EX_MEM_W = REGADDR_W + 1 + REG_W;
    localparam int unsigned MEM_WB_W = REGADDR_W + 1 + REG_W;

    localparam logic [ID_EX_W-1:0] ID_EX_NOP_VALUE =
        {EXE_NOP_OP, EXE_RES_NOP, ZeroWord, ZeroWord, NOPRegAddr, WriteDisable};
    localparam logic [EX_MEM_W-1:0] EX_MEM_NOP_VALUE =
        {NOPRegAddr, WriteDisable, ZeroWord};
    localparam logic [MEM_WB_W-1:0] MEM_WB_NOP_VALUE =
        {NOPRegAddr, WriteDisable, ZeroWord};

    // Occupancy of a boundary register: nothing, main only, main + skid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_e;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter.
//   clk, rst : clock, synchronous active-high reset (clears count)
//   inc      : add one this cycle, sticking at all-ones
//   clr      : synchronous clear, wins over inc
//   cnt      : current count
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with valid/ready handshake, flush-to-bubble and
// an optional 2-entry skid buffer, plus a saturating stall-cycle counter.
//   clk, rst          : clock, synchronous active-high reset
//   flush             : drop every held entry, present a bubble next cycle
//   in_valid/in_ready : upstream handshake, in_data sampled on accept
//   out_valid/out_ready: downstream handshake; out_data is NOP_VALUE when idle
//   stall_cnt         : cycles with out_valid && !out_ready (saturating)
//   stall_clr         : synchronous clear of stall_cnt
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned          DATA_W    = 72,
    parameter logic [DATA_W-1:0]    NOP_VALUE = '0,
    parameter bit                   SKID      = 1'b1,
    parameter int unsigned          CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    stage_state_e      state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              accept;
    logic              emit;
    logic              stall;

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = out_valid ? main_q : NOP_VALUE;
    assign accept    = in_valid && in_ready;
    assign emit      = out_valid && out_ready;
    assign stall     = out_valid && !out_ready;

    // With SKID=0 in_ready is low whenever main is held and out_ready is low,
    // so "accept without emit" never happens in ST_ONE and ST_TWO stays dead.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // An emit in this cycle already belongs downstream; an accept is lost.
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        main_d  = in_data;
                    end
                end
                ST_ONE: begin
                    if (accept && !emit) begin
                        state_d = ST_TWO;
                        skid_d  = in_data;
                    end else if (accept && emit) begin
                        main_d  = in_data;
                    end else if (emit) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (emit) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Payload registers need no reset: out_data is masked while out_valid=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
        main_q <= main_d;
        skid_q <= skid_d;
    end

    generate
        if (SKID) begin : g_skid
            logic ready_q;
            // Registered copy of "next state is not full".
            always_ff @(posedge clk) begin
                if (rst) begin
                    ready_q <= 1'b1;
                end else begin
                    ready_q <= (state_d != ST_TWO);
                end
            end
            assign in_ready = ready_q;
        end else begin : g_noskid
            assign in_ready = (state_q == ST_EMPTY) || out_ready;
        end
    endgenerate

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall),
        .clr (stall_clr),
        .cnt (stall_cnt)
    );

endmodule
